// File: rtl/if_stage_pkg.sv
// Shared fetch/decode constants: word width, reset vector and the bubble word
// decode treats as a never-executed instruction.
package if_stage_pkg;

    localparam int          IF_ADDRESS_LEN  = 32;
    localparam int          IF_QUEUE_DEPTH  = 2;
    localparam logic [31:0] IF_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] IF_BUBBLE_INSTR = 32'hF000_0000;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of packed {addr, instr} entries; clear beats push, head is a
// plain read of the storage at the read pointer.
module fetch_queue
    import if_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign do_push = push && !clear && !rst;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Upstream credit accounting must never push into a full queue without a pop.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push && !do_pop)
            assert (int'(count) < DEPTH);
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, issues in-order imem requests under a
// credit limit and presents the prefetch queue head to decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                     ADDRESS_LEN  = IF_ADDRESS_LEN,
    parameter int                     QUEUE_DEPTH  = IF_QUEUE_DEPTH,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC     = ADDRESS_LEN'(IF_RESET_PC),
    parameter logic [ADDRESS_LEN-1:0] BUBBLE_INSTR = ADDRESS_LEN'(IF_BUBBLE_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [ADDRESS_LEN-1:0] imem_rsp_data,
    output logic [ADDRESS_LEN-1:0] pc,
    output logic [ADDRESS_LEN-1:0] instruction,
    output logic                   if_valid
);

    localparam int CW = cnt_width(QUEUE_DEPTH);
    localparam int PW = $clog2(QUEUE_DEPTH);

    logic [ADDRESS_LEN-1:0]                  fetch_pc;
    logic [CW-1:0]                           count;
    logic [CW-1:0]                           outstanding;
    logic [CW-1:0]                           discard;
    logic [QUEUE_DEPTH-1:0][ADDRESS_LEN-1:0] req_addr;
    logic [PW-1:0]                           req_wr;
    logic [PW-1:0]                           req_rd;
    logic [2*ADDRESS_LEN-1:0]                head;
    logic                                    deq;
    logic                                    req_fire;
    logic                                    rsp_keep;

    assign if_valid       = (count != '0);
    assign deq            = if_valid && !freeze && !branch_taken;
    // Queue slots already spoken for (held + in flight) must leave room for one more.
    assign imem_req_valid = !rst && !branch_taken &&
                            (int'(count) + int'(outstanding) - int'(deq) < QUEUE_DEPTH);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard == '0);

    assign instruction = if_valid ? head[ADDRESS_LEN-1:0] : BUBBLE_INSTR;
    assign pc          = if_valid ? head[2*ADDRESS_LEN-1:ADDRESS_LEN] + ADDRESS_LEN'(4)
                                  : '0;

    fetch_queue #(
        .WIDTH (2*ADDRESS_LEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (deq),
        .clear (branch_taken),
        .din   ({req_addr[req_rd], imem_rsp_data}),
        .head  (head),
        .count (count)
    );

    // Every response, kept or discarded, retires the oldest tracked request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            req_wr      <= '0;
            req_rd      <= '0;
        end else begin
            if (req_fire) begin
                req_addr[req_wr] <= fetch_pc;
                req_wr           <= req_wr + 1'b1;
            end
            if (imem_rsp_valid)
                req_rd <= req_rd + 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (branch_taken) begin
                fetch_pc <= branch_address;
                discard  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + ADDRESS_LEN'(4);
                if (imem_rsp_valid && discard != '0)
                    discard <= discard - 1'b1;
            end
        end
    end

endmodule
